// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared defaults, channel-code width and idle code for prio_rr_arbiter
package arb_pkg;
   localparam int DEF_CH_NUM     = 3;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_PRIO_WIDTH = 2;

   // One extra bit beyond the channel index so the all-ones idle code never aliases a channel
   function automatic int ch_w(input int ch_num);
      return $clog2(ch_num) + 1;
   endfunction

   function automatic logic [7:0] idle_code(input int ch_num);
      return 8'((1 << ch_w(ch_num)) - 1);
   endfunction

   localparam int                    DEF_CH_W      = ch_w(DEF_CH_NUM);
   localparam logic [DEF_CH_W-1:0]   DEF_IDLE_CODE = '1;
endpackage

// File: rtl/prio_rr_arbiter_if.sv
// rtl/prio_rr_arbiter_if.sv - uplink/downlink signal bundle; slave modport is the arbiter side
interface prio_rr_arbiter_if
   import arb_pkg::*;
#(
   parameter int CH_NUM     = DEF_CH_NUM,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int PRIO_WIDTH = DEF_PRIO_WIDTH
) ();
   localparam int CH_W = ch_w(CH_NUM);

   logic [CH_NUM*PRIO_WIDTH-1:0] arb_ch_priority;
   logic [CH_NUM-1:0]            arb_uplink_valid;
   logic [CH_NUM*DATA_WIDTH-1:0] arb_ch_data_in;
   logic [CH_NUM-1:0]            arb_uplink_ready;
   logic                         arb_downlink_valid;
   logic                         arb_downlink_ready;
   logic [DATA_WIDTH-1:0]        arb_data_out;
   logic [CH_W-1:0]              arb_ch_chosen;

   modport master (
      output arb_ch_priority, arb_uplink_valid, arb_ch_data_in, arb_downlink_ready,
      input  arb_uplink_ready, arb_downlink_valid, arb_data_out, arb_ch_chosen
   );

   modport slave (
      input  arb_ch_priority, arb_uplink_valid, arb_ch_data_in, arb_downlink_ready,
      output arb_uplink_ready, arb_downlink_valid, arb_data_out, arb_ch_chosen
   );
endinterface

// File: rtl/arb_grant_sel.sv
// rtl/arb_grant_sel.sv - combinational winner pick: lowest priority value, ties to first at/after rr_ptr
module arb_grant_sel
   import arb_pkg::*;
#(
   parameter int CH_NUM     = DEF_CH_NUM,
   parameter int PRIO_WIDTH = DEF_PRIO_WIDTH,
   parameter int CH_W       = ch_w(DEF_CH_NUM)
) (
   input  logic [CH_NUM-1:0]            i_valid,
   input  logic [CH_NUM*PRIO_WIDTH-1:0] i_priority,
   input  logic [CH_W-1:0]              i_rr_ptr,
   output logic [CH_NUM-1:0]            o_grant,
   output logic                         o_found
);
   logic [PRIO_WIDTH-1:0] w_best;
   logic                  w_any;
   int                    w_dist;
   int                    w_best_dist;
   int                    w_sel;

   always_comb begin
      w_best      = '1;
      w_any       = 1'b0;
      w_dist      = 0;
      w_best_dist = CH_NUM;
      w_sel       = 0;
      o_grant     = '0;

      for (int i = 0; i < CH_NUM; i++) begin
         if (i_valid[i] && (!w_any || i_priority[i*PRIO_WIDTH +: PRIO_WIDTH] < w_best)) begin
            w_best = i_priority[i*PRIO_WIDTH +: PRIO_WIDTH];
            w_any  = 1'b1;
         end
      end

      // Among best-priority channels, the one with the shortest upward distance from rr_ptr wins
      for (int i = 0; i < CH_NUM; i++) begin
         w_dist = i - int'(i_rr_ptr);
         if (w_dist < 0)
            w_dist = w_dist + CH_NUM;
         if (i_valid[i] && i_priority[i*PRIO_WIDTH +: PRIO_WIDTH] == w_best && w_dist < w_best_dist) begin
            w_best_dist = w_dist;
            w_sel       = i;
         end
      end

      for (int i = 0; i < CH_NUM; i++)
         o_grant[i] = w_any && (w_sel == i);

      o_found = w_any;
   end
endmodule

// File: rtl/prio_rr_arbiter.sv
// rtl/prio_rr_arbiter.sv - priority arbiter with registered output stage; round-robin tie-break under PRIO_RR_ARBITER_RR_TIE_EN
module prio_rr_arbiter
   import arb_pkg::*;
#(
   parameter int CH_NUM     = DEF_CH_NUM,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int PRIO_WIDTH = DEF_PRIO_WIDTH
) (
   input  logic                clk,
   input  logic                rst_n,
   prio_rr_arbiter_if.slave    arb
);
   localparam int              CH_W = ch_w(CH_NUM);
   localparam logic [CH_W-1:0] IDLE = CH_W'(idle_code(CH_NUM));

   logic [CH_NUM-1:0]     w_grant;
   logic                  w_found;
   logic                  w_open;
   logic                  w_up_xfer;
   logic [CH_W-1:0]       w_win_idx;
   logic [DATA_WIDTH-1:0] w_win_data;
   logic [CH_W-1:0]       w_rr_ptr;

   logic                  r_dl_valid;
   logic [DATA_WIDTH-1:0] r_data;
   logic [CH_W-1:0]       r_chosen;

   arb_grant_sel #(
      .CH_NUM     (CH_NUM),
      .PRIO_WIDTH (PRIO_WIDTH),
      .CH_W       (CH_W)
   ) u_grant_sel (
      .i_valid    (arb.arb_uplink_valid),
      .i_priority (arb.arb_ch_priority),
      .i_rr_ptr   (w_rr_ptr),
      .o_grant    (w_grant),
      .o_found    (w_found)
   );

   assign w_open    = !r_dl_valid || arb.arb_downlink_ready;
   // rst_n in the term keeps every ready bit low for as long as reset is held
   assign w_up_xfer = w_found && w_open && rst_n;

   always_comb begin
      w_win_idx  = '0;
      w_win_data = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         if (w_grant[i]) begin
            w_win_idx  = CH_W'(i);
            w_win_data = arb.arb_ch_data_in[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

`ifdef PRIO_RR_ARBITER_RR_TIE_EN
   logic [CH_W-1:0] r_rr_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_rr_ptr <= '0;
      else if (w_up_xfer)
         r_rr_ptr <= (w_win_idx == CH_W'(CH_NUM - 1)) ? '0 : w_win_idx + CH_W'(1);
   end

   assign w_rr_ptr = r_rr_ptr;
`else
   assign w_rr_ptr = '0;
`endif

   // An accept always wins over a drain, so a word arriving as the old one leaves costs no bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dl_valid <= 1'b0;
         r_data     <= '0;
         r_chosen   <= IDLE;
      end else if (w_up_xfer) begin
         r_dl_valid <= 1'b1;
         r_data     <= w_win_data;
         r_chosen   <= w_win_idx;
      end else if (r_dl_valid && arb.arb_downlink_ready) begin
         r_dl_valid <= 1'b0;
         r_chosen   <= IDLE;
      end
   end

   assign arb.arb_uplink_ready   = w_up_xfer ? w_grant : '0;
   assign arb.arb_downlink_valid = r_dl_valid;
   assign arb.arb_data_out       = r_data;
   assign arb.arb_ch_chosen      = r_chosen;
endmodule

// File: tb/tb_prio_rr_arbiter.sv
// tb/tb_prio_rr_arbiter.sv - randomized bench with behavioural model plus directed scenarios
module tb_prio_rr_arbiter;
   localparam int CH_NUM = 3;
   localparam int DW     = 32;
   localparam int PW     = 2;
   localparam int CH_W   = 3;
   localparam logic [CH_W-1:0] IDLE = 3'b111;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   prio_rr_arbiter_if #(.CH_NUM(CH_NUM), .DATA_WIDTH(DW), .PRIO_WIDTH(PW)) bus ();

   prio_rr_arbiter #(.CH_NUM(CH_NUM), .DATA_WIDTH(DW), .PRIO_WIDTH(PW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .arb   (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // Model state: what the output register holds, and the tie pointer
   logic          m_valid = 1'b0;
   logic [DW-1:0] m_data  = '0;
   logic [CH_W-1:0] m_ch  = IDLE;
   int            m_ptr   = 0;

   function automatic int model_winner();
      int bp;
      int idx;
      bp = 1 << PW;
      for (int i = 0; i < CH_NUM; i++)
         if (bus.arb_uplink_valid[i] && int'(bus.arb_ch_priority[i*PW +: PW]) < bp)
            bp = int'(bus.arb_ch_priority[i*PW +: PW]);
      for (int k = 0; k < CH_NUM; k++) begin
         idx = (m_ptr + k) % CH_NUM;
         if (bus.arb_uplink_valid[idx] && int'(bus.arb_ch_priority[idx*PW +: PW]) == bp)
            return idx;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      int w;
      logic open;
      logic [CH_NUM-1:0] exp_rdy;
      if (!rst_n) begin
         m_valid = 1'b0;
         m_data  = '0;
         m_ch    = IDLE;
         m_ptr   = 0;
         chk("rst_uplink_ready", 64'(bus.arb_uplink_ready), 64'(0));
         chk("rst_downlink_valid", 64'(bus.arb_downlink_valid), 64'(0));
         chk("rst_data_out", 64'(bus.arb_data_out), 64'(0));
         chk("rst_ch_chosen", 64'(bus.arb_ch_chosen), 64'(IDLE));
      end else begin
         w = model_winner();
         open = !m_valid || bus.arb_downlink_ready;
         exp_rdy = (w >= 0 && open) ? CH_NUM'(1 << w) : '0;
         chk("model_uplink_ready", 64'(bus.arb_uplink_ready), 64'(exp_rdy));
         chk("model_downlink_valid", 64'(bus.arb_downlink_valid), 64'(m_valid));
         chk("model_data_out", 64'(bus.arb_data_out), 64'(m_data));
         chk("model_ch_chosen", 64'(bus.arb_ch_chosen), 64'(m_ch));
         if (w >= 0 && open) begin
            m_valid = 1'b1;
            m_data  = bus.arb_ch_data_in[w*DW +: DW];
            m_ch    = CH_W'(w);
`ifdef PRIO_RR_ARBITER_RR_TIE_EN
            m_ptr   = (w + 1) % CH_NUM;
`endif
         end else if (m_valid && bus.arb_downlink_ready) begin
            m_valid = 1'b0;
            m_ch    = IDLE;
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [2:0] v, input logic [5:0] p, input logic [95:0] d, input logic r);
      bus.arb_uplink_valid   = v;
      bus.arb_ch_priority    = p;
      bus.arb_ch_data_in     = d;
      bus.arb_downlink_ready = r;
   endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      int exp_ch;
      set_in(3'b000, 6'd0, 96'd0, 1'b1);
      #12;
      rst_n = 1'b1;
      next_cycle();

      // Single request: ready same cycle, word out one edge later
      set_in(3'b010, {2'd0, 2'd3, 2'd0}, {32'h0, 32'hA5, 32'h0}, 1'b1);
      #2;
      chk("single_ready", 64'(bus.arb_uplink_ready), 64'(3'b010));
      next_cycle();
      set_in(3'b000, 6'd0, 96'd0, 1'b1);
      #2;
      chk("single_dl_valid", 64'(bus.arb_downlink_valid), 64'(1));
      chk("single_data", 64'(bus.arb_data_out), 64'(32'hA5));
      chk("single_ch", 64'(bus.arb_ch_chosen), 64'(1));

      // Strict priority: ch1 holds prio 0
      for (int k = 0; k < 4; k++) begin
         next_cycle();
         set_in(3'b111, {2'd2, 2'd0, 2'd1}, {32'h22, 32'h11, 32'h00}, 1'b1);
         #2;
         chk("strict_ready", 64'(bus.arb_uplink_ready), 64'(3'b010));
      end

      // Tie rotation from a freshly reset pointer
      next_cycle();
      do_reset();
      for (int k = 0; k < 6; k++) begin
         set_in(3'b111, {2'd1, 2'd1, 2'd1}, {32'h2, 32'h1, 32'h0}, 1'b1);
`ifdef PRIO_RR_ARBITER_RR_TIE_EN
         exp_ch = k % 3;
`else
         exp_ch = 0;
`endif
         #2;
         chk("tie_ready", 64'(bus.arb_uplink_ready), 64'(1 << exp_ch));
         next_cycle();
      end

      // Backpressure on ch0
      set_in(3'b000, 6'd0, 96'd0, 1'b1);
      next_cycle();
      set_in(3'b001, 6'd0, {64'h0, 32'h100}, 1'b0);
      #2;
      chk("bp_first_ready", 64'(bus.arb_uplink_ready), 64'(3'b001));
      for (int k = 1; k < 4; k++) begin
         next_cycle();
         set_in(3'b001, 6'd0, {64'h0, 32'(32'h100 + k)}, 1'b0);
         #2;
         chk("bp_hold_ready", 64'(bus.arb_uplink_ready), 64'(0));
         chk("bp_hold_data", 64'(bus.arb_data_out), 64'(32'h100));
         chk("bp_hold_ch", 64'(bus.arb_ch_chosen), 64'(0));
      end
      next_cycle();
      set_in(3'b001, 6'd0, {64'h0, 32'h104}, 1'b1);
      #2;
      chk("bp_release_ready", 64'(bus.arb_uplink_ready), 64'(3'b001));
      next_cycle();
      #2;
      chk("bp_next_valid", 64'(bus.arb_downlink_valid), 64'(1));
      chk("bp_next_data", 64'(bus.arb_data_out), 64'(32'h104));

      // Reset mid-stream, between edges, with a word held
      rst_n = 1'b0;
      #1;
      chk("midrst_dl_valid", 64'(bus.arb_downlink_valid), 64'(0));
      chk("midrst_ch", 64'(bus.arb_ch_chosen), 64'(IDLE));
      chk("midrst_data", 64'(bus.arb_data_out), 64'(0));
      chk("midrst_ready", 64'(bus.arb_uplink_ready), 64'(0));
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      set_in(3'b111, {2'd1, 2'd1, 2'd1}, {32'h2, 32'h1, 32'h0}, 1'b1);
      #2;
      chk("postrst_ready", 64'(bus.arb_uplink_ready), 64'(3'b001));
      next_cycle();
      #2;
      chk("postrst_ch", 64'(bus.arb_ch_chosen), 64'(0));

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         next_cycle();
         bus.arb_uplink_valid   = 3'($urandom);
         bus.arb_ch_priority    = 6'($urandom);
         if ($urandom_range(0, 2) == 0)
            bus.arb_ch_priority = {3{2'($urandom)}};
         bus.arb_ch_data_in     = {$urandom, $urandom, $urandom};
         bus.arb_downlink_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) begin
            #2;
            rst_n = 1'b0;
            next_cycle();
            rst_n = 1'b1;
         end
      end

      next_cycle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
